// File: rtl/fib_lpm_engine_if.sv
// Handshake and byte-stream bundle between the FIB engine and its SPI/PIT neighbours.
interface fib_lpm_engine_if #(
  parameter int PREFIX_BYTES = 8
);
  localparam int W     = 8 * PREFIX_BYTES;
  localparam int LEN_W = $clog2(W);

  logic             RX_valid;
  logic [7:0]       data_SPI_to_FIB;
  logic [W-1:0]     pit_in_prefix;
  logic [7:0]       pit_in_metadata;
  logic             lookup_valid;
  logic             lookup_ready;
  logic             spi_ready;
  logic             FIB_to_SPI_data_flag;
  logic [7:0]       data_FIB_to_SPI;
  logic             match_hit;
  logic [LEN_W-1:0] match_len;
  logic             init_done;

  modport slave (
    input  RX_valid, data_SPI_to_FIB, pit_in_prefix, pit_in_metadata, lookup_valid, spi_ready,
    output lookup_ready, FIB_to_SPI_data_flag, data_FIB_to_SPI, match_hit, match_len, init_done
  );

  modport master (
    output RX_valid, data_SPI_to_FIB, pit_in_prefix, pit_in_metadata, lookup_valid, spi_ready,
    input  lookup_ready, FIB_to_SPI_data_flag, data_FIB_to_SPI, match_hit, match_len, init_done
  );
endinterface

// File: rtl/fib_lpm_engine.sv
// Hashed longest-prefix-match FIB: learns/unlearns prefixes from the SPI RX stream and
// answers PIT lookups by probing lengths longest-first, streaming the result back to SPI.
module fib_lpm_engine #(
  parameter int PREFIX_BYTES = 8,
  parameter int HASH_BITS    = 10,
  parameter int RX_TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst,
  fib_lpm_engine_if.slave bus
);
  localparam int W      = 8 * PREFIX_BYTES;
  localparam int LEN_W  = $clog2(W);
  localparam int DEPTH  = 1 << HASH_BITS;
  localparam int IDLE_W = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [0:0] {RX_META, RX_PREFIX} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_PROBE, L_META, L_TOTAL, L_LPM} lk_state_t;

  function automatic logic [W-1:0] mask_len(input logic [W-1:0] p, input logic [LEN_W-1:0] l);
    logic [W-1:0] ones;
    ones = '1;
    return p & ~(ones >> l);
  endfunction

  function automatic logic [HASH_BITS-1:0] hash_of(input logic [W-1:0] p, input logic [LEN_W-1:0] l);
    logic [W-1:0]         m;
    logic [HASH_BITS-1:0] h;
    m = mask_len(p, l);
    h = '0;
    for (int unsigned i = 0; i < W; i++) h[i % HASH_BITS] = h[i % HASH_BITS] ^ m[i];
    return h ^ HASH_BITS'(l);
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (int'(l) >= W) return LEN_W'(W - 1);
    return l;
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] p, input int unsigned k);
    return p[(W - 8 - 8 * k) +: 8];
  endfunction

  logic [W-1:0]         fib_mem [DEPTH];
  logic [HASH_BITS-1:0] clr_idx;
  logic                 init_done;
  logic                 clear_last;

  rx_state_t            rx_state;
  logic [3:0]           rx_cnt;
  logic [IDLE_W-1:0]    rx_idle;
  logic [7:0]           rx_meta;
  logic [W-1:0]         rx_prefix;
  logic                 wr_pending;
  logic                 wr_set;
  logic [LEN_W-1:0]     wr_len;
  logic [HASH_BITS-1:0] wr_addr;

  lk_state_t            lk_state;
  logic                 lk_ready;
  logic [W-1:0]         lk_prefix;
  logic                 lk_meta6;
  logic [LEN_W-1:0]     lk_len;
  logic                 hit;
  logic [LEN_W-1:0]     mlen;
  logic                 flag;
  logic [7:0]           tx_data;
  logic [3:0]           tx_idx;
  logic [HASH_BITS-1:0] probe_addr;
  logic                 probe_bit;
  logic [W-1:0]         lpm;

  assign clear_last = !init_done && (clr_idx == '1);
  assign wr_addr    = hash_of(rx_prefix, wr_len);
  assign probe_addr = hash_of(lk_prefix, lk_len);
  assign probe_bit  = fib_mem[probe_addr][lk_len];
  assign lpm        = mask_len(lk_prefix, mlen);

  // Clear walk owns the table until init_done; afterwards only RX commits write it.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx   <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      fib_mem[clr_idx] <= '0;
      clr_idx          <= clr_idx + 1'b1;
      if (clear_last) init_done <= 1'b1;
    end else if (wr_pending) begin
      fib_mem[wr_addr][wr_len] <= wr_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_META;
      rx_cnt     <= '0;
      rx_idle    <= '0;
      rx_meta    <= '0;
      rx_prefix  <= '0;
      wr_pending <= 1'b0;
      wr_set     <= 1'b0;
      wr_len     <= '0;
    end else begin
      wr_pending <= 1'b0;
      case (rx_state)
        RX_META: begin
          rx_idle <= '0;
          if (bus.RX_valid && init_done) begin
            rx_meta  <= bus.data_SPI_to_FIB;
            rx_cnt   <= '0;
            rx_state <= RX_PREFIX;
          end
        end
        RX_PREFIX: begin
          if (bus.RX_valid) begin
            rx_idle   <= '0;
            rx_prefix <= (rx_prefix << 8) | W'(bus.data_SPI_to_FIB);
            if (rx_cnt == 4'(PREFIX_BYTES - 1)) begin
              rx_state   <= RX_META;
              wr_pending <= rx_meta[7] | rx_meta[6];
              wr_set     <= rx_meta[7];
              wr_len     <= clamp_len(rx_meta[LEN_W-1:0]);
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end else if (rx_idle == IDLE_W'(RX_TIMEOUT - 1)) begin
            rx_state <= RX_META;
            rx_idle  <= '0;
          end else begin
            rx_idle <= rx_idle + 1'b1;
          end
        end
        default: rx_state <= RX_META;
      endcase
    end
  end

  // The first SEND_META cycle only raises the flag; bytes then advance on flag && spi_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_state  <= L_IDLE;
      lk_ready  <= 1'b0;
      lk_prefix <= '0;
      lk_meta6  <= 1'b0;
      lk_len    <= '0;
      hit       <= 1'b0;
      mlen      <= '0;
      flag      <= 1'b0;
      tx_data   <= '0;
      tx_idx    <= '0;
    end else begin
      case (lk_state)
        L_IDLE: begin
          if (bus.lookup_valid && lk_ready) begin
            lk_prefix <= bus.pit_in_prefix;
            lk_meta6  <= bus.pit_in_metadata[6];
            lk_len    <= clamp_len(bus.pit_in_metadata[LEN_W-1:0]);
            hit       <= 1'b0;
            mlen      <= '0;
            lk_ready  <= 1'b0;
            lk_state  <= L_PROBE;
          end else begin
            lk_ready <= init_done || clear_last;
          end
        end
        L_PROBE: begin
          if (probe_bit) begin
            hit      <= 1'b1;
            mlen     <= lk_len;
            lk_state <= L_META;
          end else if (lk_len == '0) begin
            hit      <= 1'b0;
            mlen     <= '0;
            lk_state <= L_META;
          end else begin
            lk_len <= lk_len - 1'b1;
          end
        end
        L_META: begin
          if (!flag) begin
            flag    <= 1'b1;
            tx_data <= {hit, lk_meta6, 6'(mlen)};
          end else if (bus.spi_ready) begin
            tx_data  <= byte_of(lk_prefix, 0);
            tx_idx   <= '0;
            lk_state <= L_TOTAL;
          end
        end
        L_TOTAL: begin
          if (bus.spi_ready) begin
            if (tx_idx == 4'(PREFIX_BYTES - 1)) begin
              tx_data  <= byte_of(lpm, 0);
              tx_idx   <= '0;
              lk_state <= L_LPM;
            end else begin
              tx_data <= byte_of(lk_prefix, 32'(tx_idx) + 32'd1);
              tx_idx  <= tx_idx + 1'b1;
            end
          end
        end
        L_LPM: begin
          if (bus.spi_ready) begin
            if (tx_idx == 4'(PREFIX_BYTES - 1)) begin
              flag     <= 1'b0;
              tx_data  <= '0;
              tx_idx   <= '0;
              lk_ready <= 1'b1;
              lk_state <= L_IDLE;
            end else begin
              tx_data <= byte_of(lpm, 32'(tx_idx) + 32'd1);
              tx_idx  <= tx_idx + 1'b1;
            end
          end
        end
        default: lk_state <= L_IDLE;
      endcase
    end
  end

  assign bus.lookup_ready         = lk_ready;
  assign bus.FIB_to_SPI_data_flag = flag;
  assign bus.data_FIB_to_SPI      = tx_data;
  assign bus.match_hit            = hit;
  assign bus.match_len            = mlen;
  assign bus.init_done            = init_done;
endmodule
